segway_drive_math: RTL

Pipelined, parametrised successor to the combinational Segway torque-math path. It sits between the balance PID and the PWM/motor drive. It owns its own soft-start ramp, applies steering mix, deadzone shaping, saturation, a per-update slew limiter and a persistence-filtered too_fast flag, and emits left/right speed commands with a valid strobe. One PID update is accepted per `pid_vld` pulse; results appear a fixed 3 cycles later.

---
 rtl/segway_drive_math.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/segway_drive_math.sv
// Segway drive math: three-stage pipeline from PID output to left/right speed commands.
// Covers soft-start, steering mix, deadzone shaping, saturation, slew limiting and a too_fast filter.
module segway_drive_math #(
    parameter int W        = 12,
    parameter int SS_BITS  = 8,
    parameter int MIN_DUTY = 168,
    parameter int LOW_BAND = 42,
    parameter int GAIN     = 4,
    parameter int SLEW     = 64,
    parameter int FAST_THR = 1536,
    parameter int FAST_CNT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pid_vld,
    input  logic signed [W-1:0] PID_cntrl,
    input  logic        [W-1:0] steer_pot,
    input  logic                en_steer,
    input  logic                pwr_up,
    output logic                spd_vld,
    output logic signed [W-1:0] lft_spd,
    output logic signed [W-1:0] rght_spd,
    output logic                too_fast,
    output logic                ss_done
);
    localparam int W1 = W + 1;
    localparam int PW = SS_BITS + W + 1;
    localparam int CW = $clog2(FAST_CNT + 1);

    localparam logic [SS_BITS-1:0]  SS_FULL   = '1;
    localparam logic [W-1:0]        STEER_LO  = W'(2 ** W / 8);
    localparam logic [W-1:0]        STEER_HI  = W'(7 * 2 ** W / 8);
    localparam logic [W-1:0]        STEER_MID = W'(2 ** (W - 1) - 1);
    localparam logic signed [W:0]   MIN_D     = W1'(MIN_DUTY);
    localparam logic signed [W:0]   LOW_B     = W1'(LOW_BAND);
    localparam logic signed [W:0]   GAIN_V    = W1'(GAIN);
    localparam logic signed [W:0]   SLEW_V    = W1'(SLEW);
    localparam logic signed [W:0]   OUT_MAX   = W1'(2 ** (W - 1) - 1);
    localparam logic signed [W:0]   OUT_MIN   = W1'(-(2 ** (W - 1)));
    localparam logic signed [W-1:0] FAST_T    = W'(FAST_THR);
    localparam logic [CW-1:0]       FC_MAX    = CW'(FAST_CNT);

    function automatic logic signed [W:0] shape(input logic signed [W:0] t, input logic pwr);
        logic signed [W:0] mag;
        mag = t[W] ? -t : t;
        if (!pwr)
            shape = '0;
        else if (mag > LOW_B)
            shape = t[W] ? t - MIN_D : t + MIN_D;
        else
            shape = t * GAIN_V;
    endfunction

    function automatic logic signed [W-1:0] clip(input logic signed [W:0] t);
        if (t > OUT_MAX)
            clip = W'(OUT_MAX);
        else if (t < OUT_MIN)
            clip = W'(OUT_MIN);
        else
            clip = W'(t);
    endfunction

    // Reference is the previously emitted output, so a clamped step can never overshoot.
    function automatic logic signed [W-1:0] slew_step(input logic signed [W-1:0] target,
                                                      input logic signed [W-1:0] prev);
        logic signed [W:0] diff;
        logic signed [W:0] step;
        diff = W1'(target) - W1'(prev);
        if (diff > SLEW_V)
            step = SLEW_V;
        else if (diff < -SLEW_V)
            step = -SLEW_V;
        else
            step = diff;
        slew_step = W'(W1'(prev) + step);
    endfunction

    logic [SS_BITS-1:0] ss_tmr;

    logic                v1, en1, pwr1;
    logic signed [W-1:0] pid_ss1, steer1;
    logic                v2, pwr2;
    logic signed [W:0]   tq_l2, tq_r2;
    logic [CW-1:0]       fast_cnt;

    logic signed [PW-1:0] prod;
    logic        [W-1:0]  pot_sat;
    logic signed [W-1:0]  offset, pid_ss_c, steer_c;
    logic signed [W:0]    pid_ext, steer_ext, t_l, t_r;
    logic signed [W-1:0]  next_l, next_r;
    logic                 over;
    logic [CW-1:0]        fast_cnt_nxt;

    always_comb begin
        prod     = PW'($signed({1'b0, ss_tmr})) * PW'(PID_cntrl);
        pid_ss_c = W'(prod >>> SS_BITS);
        if (steer_pot < STEER_LO)
            pot_sat = STEER_LO;
        else if (steer_pot > STEER_HI)
            pot_sat = STEER_HI;
        else
            pot_sat = steer_pot;
        offset  = $signed(pot_sat - STEER_MID);
        steer_c = (offset >>> 3) + (offset >>> 4);
    end

    always_comb begin
        pid_ext   = W1'(pid_ss1);
        steer_ext = W1'(steer1);
        t_l       = en1 ? pid_ext + steer_ext : pid_ext;
        t_r       = en1 ? pid_ext - steer_ext : pid_ext;
    end

    always_comb begin
        next_l = '0;
        next_r = '0;
        if (pwr2) begin
            next_l = slew_step(clip(tq_l2), lft_spd);
            next_r = slew_step(clip(tq_r2), rght_spd);
        end
        over = (next_l > FAST_T) || (next_r > FAST_T);
        if (!over)
            fast_cnt_nxt = '0;
        else if (fast_cnt == FC_MAX)
            fast_cnt_nxt = fast_cnt;
        else
            fast_cnt_nxt = fast_cnt + 1'b1;
        ss_done = (ss_tmr == SS_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_tmr  <= '0;
            v1      <= 1'b0;
            en1     <= 1'b0;
            pwr1    <= 1'b0;
            pid_ss1 <= '0;
            steer1  <= '0;
        end else begin
            v1 <= pid_vld;
            if (pid_vld) begin
                if (!pwr_up)
                    ss_tmr <= '0;
                else if (ss_tmr != SS_FULL)
                    ss_tmr <= ss_tmr + 1'b1;
                pid_ss1 <= pid_ss_c;
                steer1  <= steer_c;
                en1     <= en_steer;
                pwr1    <= pwr_up;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            pwr2  <= 1'b0;
            tq_l2 <= '0;
            tq_r2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                pwr2  <= pwr1;
                tq_l2 <= shape(t_l, pwr1);
                tq_r2 <= shape(t_r, pwr1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spd_vld  <= 1'b0;
            lft_spd  <= '0;
            rght_spd <= '0;
            too_fast <= 1'b0;
            fast_cnt <= '0;
        end else begin
            spd_vld <= v2;
            if (v2) begin
                lft_spd  <= next_l;
                rght_spd <= next_r;
                fast_cnt <= fast_cnt_nxt;
                too_fast <= (fast_cnt_nxt >= FC_MAX);
            end
        end
    end

endmodule
